// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction scheduler: command/response records,
// default field widths and the scheduler state encoding.
package i2c_pkg;

  localparam int unsigned I2C_DEV_ADDR_W = 7;
  localparam int unsigned I2C_REG_ADDR_W = 8;
  localparam int unsigned I2C_DATA_W     = 8;

  typedef struct packed {
    logic                      read;
    logic [I2C_DEV_ADDR_W-1:0] dev_addr;
    logic [I2C_REG_ADDR_W-1:0] reg_addr;
    logic [I2C_DATA_W-1:0]     wr_data;
  } i2c_cmd_t;

  typedef struct packed {
    logic [I2C_DATA_W-1:0] data;
    logic                  read;
    logic                  timeout;
  } i2c_rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RESP,
    ST_DRAIN
  } sched_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head entry is always visible
// on rdata_o while the FIFO is non-empty.
module sync_fifo
  import i2c_pkg::*;
#(
  parameter type data_t = i2c_cmd_t,
  parameter int  DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  data_t                  wdata_i,
  input  logic                   pop_i,
  output data_t                  rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;
  data_t       mem_q [DEPTH];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: storage has no reset; an entry is only read after it was written,
  // so clearing it would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/i2c_txn_scheduler.sv
// Queues I2C register commands and issues them one at a time to
// basic_i2c_master, returning one response (with timeout flag) per command.
module i2c_txn_scheduler
  import i2c_pkg::*;
#(
  parameter int DEV_ADDR_WIDTH     = I2C_DEV_ADDR_W,
  parameter int DEV_REG_ADDR_WIDTH = I2C_REG_ADDR_W,
  parameter int DATA_WIDTH         = I2C_DATA_W,
  parameter int DEPTH              = 4,
  parameter int TIMEOUT_CYCLES     = 65535
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_read_i,
  input  logic [DEV_ADDR_WIDTH-1:0]     cmd_dev_addr_i,
  input  logic [DEV_REG_ADDR_WIDTH-1:0] cmd_reg_addr_i,
  input  logic [DATA_WIDTH-1:0]         cmd_wr_data_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_read_o,
  output logic                          rsp_timeout_o,
  output logic [$clog2(DEPTH):0]        pending_o,
  output logic                          m_start_trans_o,
  output logic                          m_read_o,
  output logic [DEV_ADDR_WIDTH-1:0]     m_dev_addr_o,
  output logic [DEV_REG_ADDR_WIDTH-1:0] m_dev_reg_addr_o,
  output logic [DATA_WIDTH-1:0]         m_wr_data_o,
  input  logic [DATA_WIDTH-1:0]         m_read_data_i,
  input  logic                          m_busy_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  sched_state_e     state_q, state_d;
  i2c_cmd_t         cmd_in;
  i2c_cmd_t         fifo_head;
  i2c_cmd_t         m_q;
  i2c_rsp_t         rsp_q, rsp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             cnt_hit;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  assign cmd_in = '{
    read:     cmd_read_i,
    dev_addr: cmd_dev_addr_i,
    reg_addr: cmd_reg_addr_i,
    wr_data:  cmd_wr_data_i
  };

  sync_fifo #(
    .data_t (i2c_cmd_t),
    .DEPTH  (DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_valid_i),
    .wdata_i (cmd_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (pending_o)
  );

  // The only pop point is the IDLE->ISSUE load of the holding registers.
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

  // The counter value after this cycle's increment decides the timeout, so
  // ISSUE plus the wait cycles add up to exactly TIMEOUT_CYCLES.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign cnt_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        cnt_d = cnt_inc;
        if (cnt_hit) begin
          rsp_d   = '{data: '0, read: m_q.read, timeout: 1'b1};
          state_d = ST_RESP;
        end else if (m_busy_i) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_inc;
        if (!m_busy_i) begin
          rsp_d   = '{data: (m_q.read ? m_read_data_i : '0), read: m_q.read, timeout: 1'b0};
          state_d = ST_RESP;
        end else if (cnt_hit) begin
          rsp_d   = '{data: '0, read: m_q.read, timeout: 1'b1};
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // A timed-out master may still be mid-transfer; let it finish first.
        if (rsp_ready_i) state_d = (rsp_q.timeout && m_busy_i) ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (!m_busy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rsp_q   <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      if (fifo_pop) m_q <= fifo_head;
    end
  end

  assign cmd_ready_o      = !fifo_full;
  assign rsp_valid_o      = (state_q == ST_RESP);
  assign rsp_data_o       = rsp_q.data;
  assign rsp_read_o       = rsp_q.read;
  assign rsp_timeout_o    = rsp_q.timeout;
  assign m_start_trans_o  = (state_q == ST_ISSUE);
  assign m_read_o         = m_q.read;
  assign m_dev_addr_o     = m_q.dev_addr;
  assign m_dev_reg_addr_o = m_q.reg_addr;
  assign m_wr_data_o      = m_q.wr_data;

endmodule
